// File: rtl/io_port_responder_pkg.sv
// io_port_responder_pkg: CPU state codes, responder FSM states and the default read byte
package io_port_responder_pkg;
  localparam logic [7:0] STATE_SET_ADDR = 8'h11;
  localparam logic [7:0] STATE_OUT      = 8'h05;
  localparam logic [7:0] STATE_IN       = 8'h12;
  localparam logic [7:0] IO_RD_DEFAULT  = 8'hFF;
  typedef enum logic [1:0] {IO_IDLE, IO_WAIT_OUT, IO_WAIT_IN, IO_RESP} io_fsm_e;
  function automatic logic is_io_code(input logic [7:0] s);
    return s == STATE_SET_ADDR || s == STATE_OUT || s == STATE_IN;
  endfunction
endpackage

// File: rtl/io_port_responder_if.sv
// io_port_responder_if: CPU-side bus and per-port byte handshakes of the I/O responder
interface io_port_responder_if #(parameter int NUM_PORTS = 4);
  logic [7:0]             state;
  logic [7:0]             bus_in;
  logic [7:0]             bus_out;
  logic                   bus_oe;
  logic                   stall;
  logic                   err;
  logic                   err_clr;
  logic [8*NUM_PORTS-1:0] out_data;
  logic [NUM_PORTS-1:0]   out_valid;
  logic [NUM_PORTS-1:0]   out_ready;
  logic [8*NUM_PORTS-1:0] in_data;
  logic [NUM_PORTS-1:0]   in_valid;
  logic [NUM_PORTS-1:0]   in_ready;
  modport master (
    output state, bus_in, err_clr, out_ready, in_data, in_valid,
    input  bus_out, bus_oe, stall, err, out_data, out_valid, in_ready
  );
  modport slave (
    input  state, bus_in, err_clr, out_ready, in_data, in_valid,
    output bus_out, bus_oe, stall, err, out_data, out_valid, in_ready
  );
endinterface

// File: rtl/io_port_responder_out_buf.sv
// io_port_responder_out_buf: single-entry valid/ready holding register for one output port
module io_port_responder_out_buf (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       i_load,
  input  logic [7:0] i_load_data,
  input  logic       i_ready,
  output logic       o_valid,
  output logic [7:0] o_data
);
  logic       r_valid;
  logic [7:0] r_data;
  // Hold the byte until the device takes it; a same-cycle reload keeps the entry full
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_valid <= 1'b0;
      r_data  <= 8'h00;
    end else begin
      r_valid <= i_load || (r_valid && !i_ready);
      if (i_load) r_data <= i_load_data;
    end
  assign o_valid = r_valid;
  assign o_data  = r_data;
endmodule

// File: rtl/io_port_responder.sv
// io_port_responder: serves CPU IN/OUT cycles against per-port valid/ready byte ports
module io_port_responder
  import io_port_responder_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int TIMEOUT   = 255
) (
  input logic                clk,
  input logic                reset_n,
  io_port_responder_if.slave bus
);
  localparam int         PW       = NUM_PORTS > 1 ? $clog2(NUM_PORTS) : 1;
  localparam logic [7:0] NP8      = 8'(NUM_PORTS);
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
  io_fsm_e                r_state, w_state;
  logic [7:0]             r_addr, w_addr, r_wdata, w_wdata, r_rdata, w_rdata, r_tmo, w_tmo;
  logic [7:0]             w_load_data;
  logic                   r_err, w_err_set, w_load;
  logic [PW-1:0]          w_port;
  logic                   w_in_range, w_code, w_full, w_ready, w_in_valid;
  logic [NUM_PORTS-1:0]   w_sel, w_out_valid;
  logic [8*NUM_PORTS-1:0] w_out_data;
  assign w_port     = r_addr[PW-1:0];
  assign w_in_range = r_addr < NP8;
  assign w_code     = is_io_code(bus.state);
  assign w_sel      = NUM_PORTS'(1) << w_port;
  assign w_full     = w_out_valid[w_port];
  assign w_ready    = bus.out_ready[w_port];
  assign w_in_valid = bus.in_valid[w_port];
  // Next-state and datapath decisions; codes seen outside IDLE are dropped and flagged
  always_comb begin
    w_state     = r_state;
    w_addr      = r_addr;
    w_wdata     = r_wdata;
    w_rdata     = r_rdata;
    w_tmo       = 8'h00;
    w_load      = 1'b0;
    w_load_data = bus.bus_in;
    w_err_set   = 1'b0;
    case (r_state)
      IO_IDLE: begin
        if (bus.state == STATE_SET_ADDR) w_addr = bus.bus_in;
        else if (bus.state == STATE_OUT) begin
          if (!w_in_range) w_err_set = 1'b1;
          else if (w_full && !w_ready) begin
            w_wdata = bus.bus_in;
            w_state = IO_WAIT_OUT;
          end else w_load = 1'b1;
        end else if (bus.state == STATE_IN) begin
          if (!w_in_range) begin
            w_err_set = 1'b1;
            w_rdata   = IO_RD_DEFAULT;
            w_state   = IO_RESP;
          end else w_state = IO_WAIT_IN;
        end
      end
      IO_WAIT_OUT: begin
        w_err_set = w_code;
        if (w_full && w_ready) begin
          w_load      = 1'b1;
          w_load_data = r_wdata;
          w_state     = IO_IDLE;
        end else if (r_tmo == TMO_LAST) begin
          w_err_set = 1'b1;
          w_state   = IO_IDLE;
        end else w_tmo = r_tmo + 8'd1;
      end
      IO_WAIT_IN: begin
        w_err_set = w_code;
        if (w_in_valid) begin
          w_rdata = bus.in_data[8*w_port +: 8];
          w_state = IO_RESP;
        end else if (r_tmo == TMO_LAST) begin
          w_rdata   = IO_RD_DEFAULT;
          w_err_set = 1'b1;
          w_state   = IO_RESP;
        end else w_tmo = r_tmo + 8'd1;
      end
      default: begin
        w_err_set = w_code;
        w_state   = IO_IDLE;
      end
    endcase
  end
  // State register; err_clr wins over any same-cycle error
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_state <= IO_IDLE;
      r_addr  <= 8'h00;
      r_wdata <= 8'h00;
      r_rdata <= 8'h00;
      r_tmo   <= 8'h00;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state;
      r_addr  <= w_addr;
      r_wdata <= w_wdata;
      r_rdata <= w_rdata;
      r_tmo   <= w_tmo;
      r_err   <= bus.err_clr ? 1'b0 : r_err || w_err_set;
    end
  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_buf
    io_port_responder_out_buf u_buf (
      .clk         (clk),
      .reset_n     (reset_n),
      .i_load      (w_load && w_sel[p]),
      .i_load_data (w_load_data),
      .i_ready     (bus.out_ready[p]),
      .o_valid     (w_out_valid[p]),
      .o_data      (w_out_data[8*p +: 8])
    );
  end
  assign bus.stall     = r_state == IO_WAIT_OUT || r_state == IO_WAIT_IN ||
                         (r_state == IO_IDLE && bus.state == STATE_IN);
  assign bus.bus_oe    = r_state == IO_RESP;
  assign bus.bus_out   = r_state == IO_RESP ? r_rdata : 8'h00;
  assign bus.err       = r_err;
  assign bus.in_ready  = r_state == IO_WAIT_IN ? bus.in_valid & w_sel : '0;
  assign bus.out_valid = w_out_valid;
  assign bus.out_data  = w_out_data;
endmodule

// File: tb/tb_io_port_responder.sv
// tb_io_port_responder: randomized and directed stimulus with a queue scoreboard and device models
module tb_io_port_responder;
  import io_port_responder_pkg::*;
  localparam int NP  = 4;
  localparam int TMO = 8;
  typedef struct packed {logic [1:0] p; logic [7:0] d;} wr_t;
  typedef struct packed {logic [7:0] d; logic [31:0] c;} rd_t;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  io_port_responder_if #(.NUM_PORTS(NP)) bus();
  io_port_responder #(.NUM_PORTS(NP), .TIMEOUT(TMO)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));
  always #5 clk = ~clk;
  wr_t wq[$];
  rd_t rq[$];
  int checks = 0;
  int fails = 0;
  int irdy_exp = 0;
  int irdy_got = 0;
  logic [31:0] cyc = 0;
  logic [7:0] m_addr = 8'h00;
  logic m_err = 1'b0;
  logic [NP-1:0] rdy_rand = '0;
  logic [NP-1:0] rdy_fix = '0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
    end
  endtask
  function automatic int pend(input int p);
    int n = 0;
    foreach (wq[i]) if (wq[i].p == p[1:0]) n++;
    return n;
  endfunction
  // Device side: output ready is random but never low for more than 3 cycles in a row
  initial begin
    int lowc [NP];
    bus.out_ready = '0;
    for (int p = 0; p < NP; p++) lowc[p] = 0;
    forever begin
      @(posedge clk);
      #2;
      for (int p = 0; p < NP; p++)
        if (rdy_rand[p]) begin
          bus.out_ready[p] = lowc[p] >= 3 ? 1'b1 : 1'($urandom_range(0, 1));
          lowc[p] = bus.out_ready[p] ? 0 : lowc[p] + 1;
        end else bus.out_ready[p] = rdy_fix[p];
    end
  end
  // Monitor: pop expected reads on bus_oe and expected writes on each port handshake
  always @(negedge clk) begin
    rd_t r;
    int k;
    if (reset_n) begin
      if (bus.bus_oe) begin
        chk("rd_pending", 32'(rq.size() > 0), 1);
        if (rq.size() > 0) begin
          r = rq.pop_front();
          chk("rd_data", bus.bus_out, r.d);
          chk("rd_cycle", cyc, r.c);
        end
      end
      if (bus.in_ready != '0) begin
        irdy_got++;
        chk("in_ready_sel", bus.in_ready, 32'(1) << m_addr);
      end
      for (int p = 0; p < NP; p++)
        if (bus.out_valid[p] && bus.out_ready[p]) begin
          k = -1;
          foreach (wq[i]) if (k < 0 && wq[i].p == p[1:0]) k = i;
          chk($sformatf("wr_pending_p%0d", p), 32'(k >= 0), 1);
          if (k >= 0) begin
            chk($sformatf("wr_data_p%0d", p), bus.out_data[8*p +: 8], wq[k].d);
            wq.delete(k);
          end
        end
    end
  end
  // Present one CPU code for one cycle and record what the model expects of it
  task automatic op(input logic [7:0] code, input logic [7:0] d, output int exp_n);
    int p;
    @(posedge clk);
    #1;
    bus.state = code;
    bus.bus_in = d;
    p = int'(m_addr);
    exp_n = 0;
    if (code == STATE_SET_ADDR) m_addr = d;
    else if (code == STATE_IN) begin
      if (m_addr >= NP) begin
        rq.push_back('{8'hFF, cyc + 32'd1});
        m_err = 1'b1;
      end else if (bus.in_valid[p]) begin
        rq.push_back('{bus.in_data[8*p +: 8], cyc + 32'd2});
        irdy_exp++;
        exp_n = 1;
      end else begin
        rq.push_back('{8'hFF, cyc + 32'd1 + 32'(TMO)});
        m_err = 1'b1;
        exp_n = TMO;
      end
    end else if (code == STATE_OUT) begin
      #2;
      if (m_addr >= NP) m_err = 1'b1;
      else begin
        exp_n = (pend(p) == 0 || (pend(p) == 1 && bus.out_ready[p])) ? 0 : 1;
        wq.push_back('{p[1:0], d});
      end
    end
    @(posedge clk);
    #1;
    bus.state = 8'h00;
  endtask
  task automatic wait_done(output int n);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!bus.stall) return;
      n++;
    end
    chk("stall_bound", n, 0);
  endtask
  task automatic do_op(input logic [7:0] code, input logic [7:0] d);
    int e;
    int n;
    op(code, d, e);
    wait_done(n);
    if (code == STATE_OUT) chk("out_stall", 32'(n > 0), e);
    else chk("stall_cycles", n, e);
    chk("err", bus.err, m_err);
  endtask
  task automatic clr();
    @(posedge clk);
    #1;
    bus.err_clr = 1'b1;
    m_err = 1'b0;
    @(posedge clk);
    #1;
    bus.err_clr = 1'b0;
    @(negedge clk);
    chk("err_clr", bus.err, 0);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    int e;
    int k;
    bus.state = 8'h00;
    bus.bus_in = 8'h00;
    bus.err_clr = 1'b0;
    bus.in_valid = '0;
    bus.in_data = '0;
    repeat (3) @(posedge clk);
    #3;
    chk("rst_stall", bus.stall, 0);
    chk("rst_bus_oe", bus.bus_oe, 0);
    chk("rst_bus_out", bus.bus_out, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_in_ready", bus.in_ready, 0);
    reset_n = 1'b1;
    rdy_fix = 4'b0100;
    do_op(STATE_SET_ADDR, 8'h02);
    do_op(STATE_OUT, 8'hA5);
    chk("t1_valid_set", bus.out_valid[2], 1);
    @(negedge clk);
    chk("t1_valid_clr", bus.out_valid[2], 0);
    rdy_fix = 4'b0000;
    do_op(STATE_SET_ADDR, 8'h01);
    do_op(STATE_OUT, 8'h11);
    fork
      do_op(STATE_OUT, 8'h3C);
      begin
        repeat (5) @(posedge clk);
        rdy_fix[1] = 1'b1;
      end
    join
    bus.in_valid = 4'b0001;
    bus.in_data[7:0] = 8'h7E;
    do_op(STATE_SET_ADDR, 8'h00);
    do_op(STATE_IN, 8'h00);
    bus.in_valid = '0;
    do_op(STATE_SET_ADDR, 8'h01);
    do_op(STATE_IN, 8'h00);
    clr();
    do_op(STATE_SET_ADDR, 8'h09);
    do_op(STATE_OUT, 8'h5A);
    clr();
    do_op(STATE_IN, 8'h00);
    clr();
    bus.in_valid = 4'b0100;
    bus.in_data[23:16] = 8'h42;
    do_op(STATE_SET_ADDR, 8'h02);
    op(STATE_IN, 8'h00, e);
    @(posedge clk);
    #1;
    bus.state = STATE_OUT;
    bus.bus_in = 8'h77;
    m_err = 1'b1;
    @(posedge clk);
    #1;
    bus.state = 8'h00;
    @(negedge clk);
    chk("busy_code_err", bus.err, 1);
    clr();
    rdy_fix = '0;
    do_op(STATE_SET_ADDR, 8'h03);
    do_op(STATE_OUT, 8'hC1);
    op(STATE_OUT, 8'hC2, e);
    @(negedge clk);
    @(negedge clk);
    chk("t6_stalled", bus.stall, 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t6_rst_stall", bus.stall, 0);
    chk("t6_rst_valid", bus.out_valid, 0);
    wq.delete();
    rq.delete();
    m_addr = 8'h00;
    m_err = 1'b0;
    rdy_rand = '1;
    @(posedge clk);
    #3;
    reset_n = 1'b1;
    do_op(STATE_OUT, 8'h99);
    for (int i = 0; i < 200; i++) begin
      k = $urandom_range(0, 99);
      if (k < 20) do_op(STATE_SET_ADDR, $urandom_range(0, 3) == 0 ? 8'($urandom_range(4, 255)) : 8'($urandom_range(0, 3)));
      else if (k < 55) do_op(STATE_OUT, 8'($urandom));
      else if (k < 88) begin
        for (int p = 0; p < NP; p++) bus.in_valid[p] = $urandom_range(0, 3) != 0;
        bus.in_data = 32'($urandom);
        do_op(STATE_IN, 8'h00);
      end else clr();
    end
    rdy_rand = '0;
    rdy_fix = '1;
    repeat (4) @(negedge clk);
    chk("drain_writes", wq.size(), 0);
    chk("drain_reads", rq.size(), 0);
    chk("in_ready_count", irdy_got, irdy_exp);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
